// File: rtl/micro_painter_pkg.sv
// Shared types and APA102 framing constants for the column painter.
package micro_painter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_LED,
    S_END
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam int WORD_BITS  = 32;
  localparam int START_BITS = 32;
  localparam int END_BITS   = 32;
  localparam logic [2:0] LED_HEADER = 3'b111;

  localparam logic [WORD_BITS-1:0] START_WORD = '0;
  localparam logic [WORD_BITS-1:0] END_WORD   = '1;

  // The strip expects colour bytes in B, G, R order after the header byte.
  function automatic logic [WORD_BITS-1:0] led_word(input logic [4:0] bri, input pixel_t px);
    return {LED_HEADER, bri, px.b, px.g, px.r};
  endfunction

endpackage

// File: rtl/apa102_shifter.sv
// 32-bit MSB-first serializer: sclk low CLK_DIV cycles then high CLK_DIV cycles per bit.
module apa102_shifter
  import micro_painter_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] word,
  output logic                 done,
  output logic                 sclk,
  output logic                 sdo
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WORD_BITS);

  logic [WORD_BITS-1:0] shreg;
  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 active;
  logic                 half_end;

  assign half_end = active && (div_cnt == DW'(CLK_DIV - 1));
  // Asserted during the final high cycle so the next word can be loaded on
  // the same edge that ends it; words then abut with no idle gap.
  assign done     = half_end && sclk && (bit_cnt == BW'(WORD_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
    end else if (load) begin
      shreg   <= word;
      sdo     <= word[WORD_BITS-1];
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (half_end) begin
      div_cnt <= '0;
      if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
        if (done) begin
          active <= 1'b0;
          sdo    <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shreg   <= {shreg[WORD_BITS-2:0], 1'b0};
          sdo     <= shreg[WORD_BITS-2];
        end
      end
    end else if (active) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_column_driver.sv
// Accumulates encoder steps into a clamped column index and streams that
// column's pixels from RAM to an APA102 strip whenever the column changes.
module led_column_driver
  import micro_painter_pkg::*;
#(
  parameter int NUM_LEDS      = 8,
  parameter int NUM_COLS      = 64,
  parameter int STEPS_PER_COL = 4,
  parameter int CLK_DIV       = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  step,
  input  logic                                  dir,
  input  logic                                  enable,
  input  logic [4:0]                            brightness,
  output logic                                  mem_rd,
  output logic [$clog2(NUM_LEDS*NUM_COLS)-1:0]  mem_addr,
  input  logic [23:0]                           mem_data,
  output logic                                  sclk,
  output logic                                  sdo,
  output logic                                  busy,
  output logic [$clog2(NUM_COLS)-1:0]           col
);

  localparam int AW = $clog2(NUM_LEDS * NUM_COLS);
  localparam int CW = $clog2(NUM_COLS);
  localparam int SW = (STEPS_PER_COL > 1) ? $clog2(STEPS_PER_COL) : 1;
  localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  state_t               state;
  logic [SW-1:0]        sub;
  logic                 pending;
  logic [CW-1:0]        frame_col;
  logic [LW-1:0]        led;
  logic                 fetch_ph;
  logic                 sub_top;
  logic                 col_inc;
  logic                 col_dec;
  logic                 col_chg;
  logic                 start;
  logic                 last_led;
  logic                 shift_done;
  logic                 load;
  logic [WORD_BITS-1:0] word;

  function automatic logic [AW-1:0] pix_addr(input logic [CW-1:0] c, input logic [LW-1:0] l);
    return AW'(c) * AW'(NUM_LEDS) + AW'(l);
  endfunction

  // Sub-step always wraps; the column itself saturates at both ends.
  assign sub_top  = (sub == SW'(STEPS_PER_COL - 1));
  assign col_inc  = step && dir && sub_top && (col != CW'(NUM_COLS - 1));
  assign col_dec  = step && !dir && (sub == '0) && (col != '0);
  assign col_chg  = col_inc || col_dec;
  assign start    = (state == S_IDLE) && pending && enable;
  assign last_led = (led == LW'(NUM_LEDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub     <= '0;
      col     <= '0;
      pending <= 1'b0;
    end else begin
      if (step) begin
        if (dir) sub <= sub_top ? '0 : sub + 1'b1;
        else     sub <= (sub == '0) ? SW'(STEPS_PER_COL - 1) : sub - 1'b1;
      end
      if (col_inc)      col <= col + 1'b1;
      else if (col_dec) col <= col - 1'b1;
      // A change landing on the start edge belongs to the next frame.
      if (col_chg)    pending <= 1'b1;
      else if (start) pending <= 1'b0;
    end
  end

  always_comb begin
    load = 1'b0;
    word = '0;
    case (state)
      S_IDLE: if (start) begin
        load = 1'b1;
        word = START_WORD;
      end
      S_FETCH: if (fetch_ph) begin
        load = 1'b1;
        word = led_word(brightness, pixel_t'(mem_data));
      end
      S_LED: if (shift_done && last_led) begin
        load = 1'b1;
        word = END_WORD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      frame_col <= '0;
      led       <= '0;
      fetch_ph  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state     <= S_START;
          busy      <= 1'b1;
          frame_col <= col;
          led       <= '0;
        end
        S_START: if (shift_done) begin
          state    <= S_FETCH;
          fetch_ph <= 1'b0;
          mem_rd   <= 1'b1;
          mem_addr <= pix_addr(frame_col, led);
        end
        // Phase 0 issues the read; phase 1 sees the RAM data and loads it.
        S_FETCH: if (!fetch_ph) begin
          fetch_ph <= 1'b1;
          mem_rd   <= 1'b0;
        end else begin
          state <= S_LED;
        end
        S_LED: if (shift_done) begin
          if (last_led) begin
            state <= S_END;
          end else begin
            led      <= led + 1'b1;
            state    <= S_FETCH;
            fetch_ph <= 1'b0;
            mem_rd   <= 1'b1;
            mem_addr <= pix_addr(frame_col, led + 1'b1);
          end
        end
        S_END: if (shift_done) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  apa102_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .word  (word),
    .done  (shift_done),
    .sclk  (sclk),
    .sdo   (sdo)
  );

endmodule

// File: tb/tb_led_column_driver.sv
// Scoreboard bench: an abstract frame model predicts SPI words and RAM reads.
module tb_led_column_driver;

  localparam int NL = 8;
  localparam int NC = 64;
  localparam int SPC = 4;
  localparam int CD = 4;
  localparam int AW = $clog2(NL * NC);
  localparam int CW = $clog2(NC);
  localparam int FRAME_LEN = (64 + 32 * NL) * 2 * CD + 2 * NL;

  logic          clk = 0;
  logic          reset = 1;
  logic          step = 0;
  logic          dir = 0;
  logic          enable = 0;
  logic [4:0]    brightness = 5'h1F;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_data = '0;
  logic          sclk, sdo, busy;
  logic [CW-1:0] col;

  always #5 clk = ~clk;

  led_column_driver #(.NUM_LEDS(NL), .NUM_COLS(NC), .STEPS_PER_COL(SPC), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .step(step), .dir(dir), .enable(enable),
    .brightness(brightness), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .sclk(sclk), .sdo(sdo), .busy(busy), .col(col)
  );

  logic [23:0] mem [NL*NC];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int checks = 0, errors = 0;
  int m_col = 0, m_sub = 0, m_left = 0;
  bit m_pend = 0, m_busy = 0;
  logic [31:0] exp_words[$];
  int          exp_addr[$];

  int run_len = 0, last_len = 0, dut_frames = 0, rd_cnt = 0, first_addr = -1, last_addr = -1;
  int idle_tick = 0, prev_mcol = 0, rx_bits = 0, rx_idx = 0;
  logic prev_busy = 0, prev_mbusy = 0;
  logic [CW-1:0] prev_col = '0;
  logic [31:0] rx_word = '0, led0_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_sub = 0; m_pend = 0; m_busy = 0; m_left = 0;
  endtask

  task automatic push_frame(input int c);
    logic [23:0] p;
    exp_words.push_back(32'h0);
    for (int i = 0; i < NL; i++) begin
      p = mem[c*NL+i];
      exp_words.push_back({3'b111, brightness, p[7:0], p[15:8], p[23:16]});
      exp_addr.push_back(c*NL+i);
    end
    exp_words.push_back(32'hFFFF_FFFF);
  endtask

  // Abstract model: column arithmetic, a pending flag and a fixed-length frame timer.
  task automatic model_tick(input bit st, input bit d, input bit en);
    bit go;
    int nc;
    go = !m_busy && m_pend && en;
    nc = m_col;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) m_busy = 0;
    end
    if (st) begin
      if (d) begin
        if (m_sub == SPC-1) begin m_sub = 0; if (m_col < NC-1) nc = m_col + 1; end
        else m_sub++;
      end else begin
        if (m_sub == 0) begin m_sub = SPC-1; if (m_col > 0) nc = m_col - 1; end
        else m_sub--;
      end
    end
    if (go) begin
      m_busy = 1;
      m_left = FRAME_LEN;
      push_frame(m_col);
    end
    if (nc != m_col) m_pend = 1;
    else if (go) m_pend = 0;
    m_col = nc;
  endtask

  initial forever begin
    @(posedge clk);
    if (!reset) model_reset();
    else model_tick(step, dir, enable);
  end

  // Cycle monitor: busy/col on change, RAM reads against the address queue.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (busy !== prev_busy || m_busy != prev_mbusy) chk("busy", busy, m_busy);
      if (col !== prev_col || m_col != prev_mcol) chk("col", col, m_col);
      if (busy && !prev_busy) rd_cnt = 0;
      if (mem_rd) begin
        if (rd_cnt == 0) first_addr = mem_addr;
        last_addr = mem_addr;
        rd_cnt++;
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_addr actual=%0d required=none", mem_addr);
        end else chk("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (busy) run_len++;
      else if (prev_busy) begin last_len = run_len; run_len = 0; dut_frames++; end
      if (!busy && !m_busy) begin
        if (idle_tick % 64 == 0) chk("idle_lines", {sclk, sdo}, 0);
        idle_tick++;
      end
    end
    prev_busy = busy; prev_mbusy = m_busy; prev_col = col; prev_mcol = m_col;
  end

  // SPI receiver: strip samples sdo on rising sclk.
  initial forever begin
    @(posedge sclk or negedge reset);
    if (!reset) begin
      rx_bits = 0; rx_idx = 0;
    end else begin
      rx_word = {rx_word[30:0], sdo};
      rx_bits++;
      if (rx_bits == 32) begin
        rx_bits = 0;
        if (rx_idx == 1) led0_word = rx_word;
        rx_idx = (rx_idx == NL + 1) ? 0 : rx_idx + 1;
        if (exp_words.size() == 0) begin
          checks++; errors++;
          $display("FAIL spi_word actual=%08h required=none", rx_word);
        end else chk("spi_word", rx_word, exp_words.pop_front());
      end
    end
  end

  task automatic do_steps(input int n, input bit d, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); step = 1; dir = d;
      @(negedge clk); step = 0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || m_busy || (m_pend && enable)) && n < 20000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL %s timeout actual=%0d cycles required<20000", name, n);
    end
  endtask

  int f0;

  initial begin
    for (int i = 0; i < NL*NC; i++) mem[i] = 24'($urandom);
    mem[8] = 24'h112233;
    #1 reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_col", col, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 1;

    // Reset in the middle of an LED word
    enable = 1;
    do_steps(4, 1, 0);
    repeat (1200) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    @(posedge clk); #2 reset = 0;
    #1;
    chk("async_sclk", sclk, 0);
    chk("async_busy", busy, 0);
    chk("async_col", col, 0);
    model_reset();
    exp_words.delete(); exp_addr.delete();
    run_len = 0; prev_busy = 0;
    @(negedge clk); @(negedge clk); reset = 1;
    repeat (100) @(negedge clk);
    chk("post_reset_busy", busy, 0);

    // Clamp at column 0
    do_steps(4, 0, 1);
    repeat (20) @(negedge clk);
    chk("clamp_low_col", col, 0);
    chk("clamp_low_busy", busy, 0);

    // Forward one column
    do_steps(4, 1, 2);
    chk("fwd_col", col, 1);
    wait_idle("fwd_frame");
    chk("frame_len", last_len, FRAME_LEN);
    chk("led0_word", led0_word, 32'hFF33_2211);
    chk("fwd_first_addr", first_addr, 8);
    chk("fwd_last_addr", last_addr, 15);

    // Enable gate
    enable = 0;
    do_steps(4, 0, 0);
    do_steps(8, 1, 0);
    repeat (50) @(negedge clk);
    chk("gate_busy", busy, 0);
    chk("gate_col", col, 2);
    f0 = dut_frames;
    enable = 1;
    wait_idle("gate_frame");
    chk("gate_frames", dut_frames - f0, 1);
    chk("gate_first_addr", first_addr, 16);

    // Collapse of changes during a frame
    enable = 0;
    do_steps(12, 1, 0);
    f0 = dut_frames;
    enable = 1;
    repeat (5) @(negedge clk);
    chk("collapse_busy", busy, 1);
    repeat (300) @(negedge clk);
    do_steps(4, 1, 3);
    repeat (100) @(negedge clk);
    do_steps(4, 1, 3);
    wait_idle("collapse_frames");
    chk("collapse_frames", dut_frames - f0, 2);
    chk("collapse_first_addr", first_addr, 56);
    chk("collapse_last_addr", last_addr, 63);

    // Clamp at the last column
    enable = 0;
    do_steps((NC - 1 - 7) * SPC + 4, 1, 0);
    chk("clamp_high_col", col, NC - 1);
    enable = 1;
    wait_idle("clamp_high_frame");
    f0 = dut_frames;
    do_steps(4, 1, 1);
    repeat (30) @(negedge clk);
    chk("clamp_high_col2", col, NC - 1);
    chk("clamp_high_busy", busy, 0);
    chk("clamp_high_frames", dut_frames - f0, 0);

    // Randomized stepping with enable toggling
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      step = ($urandom_range(0, 7) == 0);
      dir = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 199) == 0) enable = ~enable;
    end
    @(negedge clk); step = 0; enable = 1;
    wait_idle("random_drain");
    repeat (10) @(negedge clk);
    chk("final_col", col, m_col);
    chk("words_left", exp_words.size(), 0);
    chk("addrs_left", exp_addr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
